// File: rtl/losowanie_sched.sv
// losowanie_sched: shares one free-running modulo counter among PLAYERS press
// inputs and hands each player one unique value in 1..VALUES per game
// (draw without replacement), arbitrating simultaneous requests round-robin.
module losowanie_sched #(
  parameter int PLAYERS = 4,
  parameter int VALUES  = 6,
  parameter int PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1,
  parameter int VW      = $clog2(VALUES + 1)
) (
  input  logic               clock,
  input  logic               reset_,
  input  logic [PLAYERS-1:0] press,
  input  logic               clear,
  output logic               result_valid,
  output logic [VW-1:0]      result,
  output logic [PW-1:0]      player,
  output logic               busy,
  output logic               exhausted
);

  localparam int            CW       = (VALUES > 1) ? $clog2(VALUES) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(VALUES - 1);
  localparam logic [PW-1:0] LAST_PLR = PW'(PLAYERS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      counter_q, counter_d;
  logic [CW-1:0]      cand_q, cand_d;
  logic [VALUES-1:0]  used_q, used_d;
  logic [PLAYERS-1:0] served_q, served_d;
  logic [PLAYERS-1:0] pending_q, pending_d;
  logic [PLAYERS-1:0] press_q, press_d;
  logic [PW-1:0]      rr_last_q, rr_last_d;
  logic [PW-1:0]      win_q, win_d;
  logic               result_valid_q, result_valid_d;
  logic [VW-1:0]      result_q, result_d;
  logic [PW-1:0]      player_q, player_d;

  logic [PLAYERS-1:0] press_edge;
  logic [PW-1:0]      rr_idx;
  logic [PW-1:0]      winner;
  logic               winner_found;

  assign exhausted    = &used_q;
  assign busy         = (state_q == CHECK);
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign player       = player_q;

  // Round-robin search: first pending player after the last one granted.
  always_comb begin
    winner       = rr_last_q;
    winner_found = 1'b0;
    rr_idx       = rr_last_q;
    for (int i = 0; i < PLAYERS; i++) begin
      rr_idx = (rr_idx == LAST_PLR) ? '0 : rr_idx + 1'b1;
      if (!winner_found && pending_q[rr_idx]) begin
        winner       = rr_idx;
        winner_found = 1'b1;
      end
    end
  end

  // Counter, press edge capture, draw FSM and new-game clear.
  always_comb begin
    counter_d      = (counter_q == LAST_VAL) ? '0 : counter_q + 1'b1;
    press_d        = press;
    state_d        = state_q;
    cand_d         = cand_q;
    used_d         = used_q;
    served_d       = served_q;
    pending_d      = pending_q;
    rr_last_d      = rr_last_q;
    win_d          = win_q;
    result_valid_d = 1'b0;
    result_d       = result_q;
    player_d       = player_q;

    press_edge = press & ~press_q & ~served_q;
    if (!exhausted) begin
      pending_d = pending_q | press_edge;
    end

    case (state_q)
      IDLE: begin
        if (winner_found && !exhausted) begin
          cand_d    = counter_q;
          win_d     = winner;
          rr_last_d = winner;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (used_q[cand_q]) begin
          cand_d = (cand_q == LAST_VAL) ? '0 : cand_q + 1'b1;
        end else begin
          used_d[cand_q]   = 1'b1;
          served_d[win_q]  = 1'b1;
          pending_d[win_q] = 1'b0;
          result_d         = VW'(cand_q) + 1'b1;
          player_d         = win_q;
          result_valid_d   = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Once every value is gone, leftover requests can never be served.
    if (exhausted) begin
      pending_d = '0;
    end

    if (clear) begin
      used_d         = '0;
      served_d       = '0;
      pending_d      = '0;
      state_d        = IDLE;
      result_valid_d = 1'b0;
      result_d       = result_q;
      player_d       = player_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      cand_q         <= '0;
      used_q         <= '0;
      served_q       <= '0;
      pending_q      <= '0;
      press_q        <= '0;
      rr_last_q      <= LAST_PLR;
      win_q          <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      player_q       <= '0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      cand_q         <= cand_d;
      used_q         <= used_d;
      served_q       <= served_d;
      pending_q      <= pending_d;
      press_q        <= press_d;
      rr_last_q      <= rr_last_d;
      win_q          <= win_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      player_q       <= player_d;
    end
  end

endmodule

// File: tb/tb_losowanie_sched.sv
// tb_losowanie_sched: scoreboard bench for the draw scheduler (8 players,
// 6 values). Expected draws are pushed when presses are driven and popped
// when result_valid pulses.
module tb_losowanie_sched;

  logic       clock;
  logic       reset_;
  logic [7:0] press;
  logic       clear;
  logic       result_valid;
  logic [2:0] result;
  logic [2:0] player;
  logic       busy;
  logic       exhausted;

  typedef struct {
    int val;
    int plr;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  int tests_run;
  int tests_failed;
  int cyc;
  int rel;
  logic [5:0] m_used;
  logic [7:0] m_served;
  int m_rr;
  int m_last_val;
  int m_last_plr;

  losowanie_sched #(.PLAYERS(8), .VALUES(6)) dut (
    .clock        (clock),
    .reset_       (reset_),
    .press        (press),
    .clear        (clear),
    .result_valid (result_valid),
    .result       (result),
    .player       (player),
    .busy         (busy),
    .exhausted    (exhausted)
  );

  initial clock = 1'b0;
  // Free-running bench clock.
  always #5 clock = ~clock;

  // Absolute posedge count used for latency expectations.
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: compare each valid pulse against the oldest expected draw.
  always @(negedge clock) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_valid result=%0d player=%0d cycle=%0d", result, player, cyc);
      end else begin
        e_mon = sb.pop_front();
        tests_run += 3;
        if (result !== 3'(e_mon.val)) begin
          tests_failed++;
          $display("[TB] FAIL draw_value got=%0d want=%0d", result, e_mon.val);
        end
        if (player !== 3'(e_mon.plr)) begin
          tests_failed++;
          $display("[TB] FAIL draw_player got=%0d want=%0d", player, e_mon.plr);
        end
        if (cyc != e_mon.at) begin
          tests_failed++;
          $display("[TB] FAIL draw_timing got_cycle=%0d want_cycle=%0d", cyc, e_mon.at);
        end
      end
    end else if (sb.size() != 0 && cyc >= sb[0].at) begin
      e_mon = sb.pop_front();
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missing_draw got=none want value=%0d player=%0d cycle=%0d", e_mon.val, e_mon.plr, e_mon.at);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait until the counter sampled by an IDLE grant two edges later equals target.
  task automatic wait_ctr(input int target);
    for (int n = 0; n < 12 && ((cyc + 1 - rel) % 6) != target; n++) tick();
  endtask

  task automatic probe(input int start, output int val, output int extra);
    val = 0;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (val == 0 && !m_used[(start + k) % 6]) begin
        m_used[(start + k) % 6] = 1'b1;
        val = (start + k) % 6 + 1;
        extra = k;
      end
    end
  endtask

  // Presses rising now are sampled at the next edge; predict every draw.
  task automatic expect_draws(input logic [7:0] mask);
    logic [7:0] pend;
    int t, val, extra, w;
    exp_t item;
    pend = mask & ~m_served;
    if (&m_used) pend = '0;
    t = cyc + 2;
    while (pend != 0) begin
      w = -1;
      for (int i = 1; i <= 8; i++) begin
        if (w < 0 && pend[(m_rr + i) % 8]) w = (m_rr + i) % 8;
      end
      probe((t - 1 - rel) % 6, val, extra);
      item.val = val;
      item.plr = w;
      item.at  = t + 1 + extra;
      sb.push_back(item);
      m_last_val = val;
      m_last_plr = w;
      m_served[w] = 1'b1;
      pend[w] = 1'b0;
      m_rr = w;
      if (&m_used) pend = '0;
      t = t + 2 + extra;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
  endtask

  task automatic press_mask(input logic [7:0] mask);
    press = mask;
    expect_draws(mask);
    drain();
    tick();
    tick();
    press = '0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_used = '0;
    m_served = '0;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    press = 8'h0F;
    clear = 1'b0;
    tick();
    tick();
    tests_run += 5;
    if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got=%b want=0", result_valid); end
    if (result !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_result got=%0d want=0", result); end
    if (player !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_player got=%0d want=0", player); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    if (exhausted !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_exhausted got=%b want=0", exhausted); end
    press = '0;
    tick();
    reset_ = 1'b1;
    rel = cyc;
    m_used = '0;
    m_served = '0;
    m_rr = 7;
    tick();
  endtask

  task automatic test_single();
    wait_ctr(3);
    press = 8'h01;
    expect_draws(8'h01);
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_busy_early got=%b want=0", busy); end
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy_check got=%b want=1", busy); end
    tick();
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_busy_done got=%b want=0", busy); end
    if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid got=%b want=1", result_valid); end
    if (result !== 3'd4) begin tests_failed++; $display("[TB] FAIL single_result got=%0d want=4", result); end
    repeat (5) tick();
    tests_run += 2;
    if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_pulse got=%b want=0", result_valid); end
    if (result !== 3'd4) begin tests_failed++; $display("[TB] FAIL single_hold got=%0d want=4", result); end
    press = '0;
    tick();
  endtask

  task automatic test_collision();
    do_clear();
    wait_ctr(5);
    press_mask(8'h02);
    wait_ctr(0);
    press_mask(8'h04);
    wait_ctr(5);
    press_mask(8'h08);
    tests_run++;
    if (result !== 3'd2) begin tests_failed++; $display("[TB] FAIL collision_result got=%0d want=2", result); end
  endtask

  task automatic test_arbitration();
    do_clear();
    press_mask(8'h01);
    press_mask(8'h06);
    do_clear();
    press_mask(8'h09);
    tests_run++;
    if (player !== 3'd0) begin tests_failed++; $display("[TB] FAIL arb_last_player got=%0d want=0", player); end
  endtask

  task automatic test_exhaustion();
    do_clear();
    press_mask(8'hFF);
    repeat (4) tick();
    tests_run += 2;
    if (exhausted !== 1'b1) begin tests_failed++; $display("[TB] FAIL exhaust_flag got=%b want=1", exhausted); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL exhaust_idle got=%b want=0", busy); end
    do_clear();
    tests_run++;
    if (exhausted !== 1'b0) begin tests_failed++; $display("[TB] FAIL exhaust_clear got=%b want=0", exhausted); end
    press_mask(8'hFF);
    do_clear();
  endtask

  task automatic test_clear_edge();
    press = 8'h10;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_used = '0;
    m_served = '0;
    repeat (6) tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_edge_busy got=%b want=0", busy); end
    press = '0;
    tick();
  endtask

  task automatic test_abort();
    press = 8'h01;
    m_rr = 0;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_busy_before got=%b want=1", busy); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run += 4;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy_after got=%b want=0", busy); end
    if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_valid got=%b want=0", result_valid); end
    if (result !== 3'(m_last_val)) begin tests_failed++; $display("[TB] FAIL abort_result_hold got=%0d want=%0d", result, m_last_val); end
    if (player !== 3'(m_last_plr)) begin tests_failed++; $display("[TB] FAIL abort_player_hold got=%0d want=%0d", player, m_last_plr); end
    m_used = '0;
    m_served = '0;
    press = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_abort();
    press = 8'h02;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_abort_busy_before got=%b want=1", busy); end
    #2;
    reset_ = 1'b0;
    #1;
    tests_run += 4;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_abort_busy got=%b want=0", busy); end
    if (result !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_abort_result got=%0d want=0", result); end
    if (player !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_abort_player got=%0d want=0", player); end
    if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_abort_valid got=%b want=0", result_valid); end
    press = 8'h20;
    tick();
    reset_ = 1'b1;
    rel = cyc;
    m_used = '0;
    m_served = '0;
    m_rr = 7;
    expect_draws(8'h20);
    drain();
    tick();
    press = '0;
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    rel = 0;
    m_used = '0;
    m_served = '0;
    m_rr = 7;
    m_last_val = 0;
    m_last_plr = 0;
    reset_ = 1'b0;
    press = '0;
    clear = 1'b0;
    test_reset();
    test_single();
    test_collision();
    test_arbitration();
    test_exhaustion();
    test_clear_edge();
    test_abort();
    test_reset_abort();
    drain();
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/losowanie_sched.md
# losowanie_sched

Multi-player draw scheduler for the lottery emulator: shares one free-running modulo counter among PLAYERS press inputs and hands each player one unique value in 1..VALUES (draw without replacement). It detects press edges, arbitrates simultaneous requests round-robin, probes past values that are already taken, and reports each draw with a one-cycle valid pulse. It sits between the input front end (mouse/button sampling) and the display/`$display` reporting logic.

## Interface
- PLAYERS, 4: number of requesters; ≥1.
- VALUES, 6: number of drawable values; ≥2; results are 1..VALUES.
- PW, $clog2(PLAYERS) (min 1): player index width.
- VW, $clog2(VALUES+1): result width.

- clock  in  1  sole clock; all state on posedge.
- reset_  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- press  in  PLAYERS  per-player press level, active-high, already synchronous to clock.
- clear  in  1  synchronous new-game strobe.
- result_valid  out  1  one-cycle pulse: a draw completed.
- result  out  VW  drawn value 1..VALUES; held until next draw.
- player  out  PW  index of the player owning `result`; held.
- busy  out  1  high while not IDLE.
- exhausted  out  1  all VALUES values drawn.

## Operation
- Reset (asynchronous, while reset_=0): counter=0, used=0, served=0, pending=0, press_q=0, rr_last=PLAYERS-1, state=IDLE, cand=0; outputs result_valid=0, result=0, player=0, busy=0, exhausted=0.
- Counter: increments every cycle, wraps VALUES-1→0; never stops (not affected by clear).
- Edge detect: press_q <= press; pending[i] set when press[i] & ~press_q[i] & ~served[i] & ~exhausted. Levels held high do not re-request.
- Pending bits are sticky until served or cleared; served players' presses are ignored until clear.
- FSM states IDLE, CHECK:
  - IDLE: if pending≠0, pick winner = first set bit searching rr_last+1, rr_last+2, … (mod PLAYERS); cand <= counter; win <= winner; rr_last <= winner; go CHECK. Otherwise stay.
  - CHECK: if used[cand]: cand <= (cand==VALUES-1) ? 0 : cand+1; stay. Else: used[cand] <= 1; served[win] <= 1; pending[win] <= 0; result <= cand+1; player <= win; result_valid <= 1 for one cycle; go IDLE.
- CHECK terminates within VALUES cycles: entering CHECK requires exhausted=0, so a free value exists.
- exhausted = &used (registered view of used; deasserts on clear).
- If PLAYERS > VALUES, remaining pending requests when exhausted rises are dropped (pending cleared); no result_valid for them.
- clear (priority over everything except reset): used, served, pending <= 0; state <= IDLE; rr_last unchanged; a CHECK in progress aborts with no result_valid; result/player hold last values.
- A press edge in the same cycle as clear is discarded.
- result_valid is 0 in every cycle other than the completing CHECK cycle's successor.

## Timing
- Press edge sampled at posedge k → pending visible after k.
- posedge k+1: IDLE grants, cand = counter value present before k+1.
- posedge k+2 (free candidate): result_valid=1 during the cycle after k+2. Minimum latency: 3 clocks from press rising to result_valid.
- Each taken value probed adds one clock; worst case VALUES-1 extra.
- Back-to-back: after a REPORT, next grant earliest at following posedge; one draw per 2 clocks max.
- busy=1 exactly in CHECK cycles.
- reset_ deassertion mid-operation: next posedge behaves as first post-reset cycle; press held high across reset release counts as an edge (press_q=0).

## Test plan
- Reset: hold reset_=0 with press=4'b1111 → all outputs 0; release, counter observed 0,1,…,5,0 wrap.
- Single draw: press[0] rises so IDLE samples counter=3 → 3 clocks later result_valid pulse, result=4, player=0, busy high one cycle; holding press adds no second draw.
- Collision/wrap: pre-draw values 6 and 1, then a draw capturing counter=5 → probes 5(used),0(used),1 → result=2, result_valid 2 clocks later than the no-collision case.
- Arbitration: press[1] and press[2] rise same cycle after rr_last=0 → player 1 reported first, player 2 two clocks later; then press[0],press[3] same cycle with rr_last=2 → player 3 before player 0.
- Exhaustion and clear: PLAYERS=8, VALUES=6, all press → six unique results covering 1..6, exhausted=1, two leftover requests dropped; clear → exhausted=0, all players may draw again.
- Abort: assert clear during CHECK → no result_valid, busy drops next cycle; separately pull reset_ low mid-CHECK → outputs 0 immediately, asynchronously.
